ps2_packet_sequencer: RTL and testbench
=======================================

Name: ps2_packet_sequencer

Overview:
Sequences the PS/2 mouse byte-capture datapath. Aligns the incoming byte stream to 3-byte packet boundaries using the sync bit (bit 3 of byte 1). Resynchronises on inter-byte timeout. Buffers complete packets in a small FIFO with a valid/ready interface to the downstream consumer.

Parameters:
DEPTH, 4, packet FIFO entries (power of 2, at least 2)
TIMEOUT, 1024, max idle cycles between bytes of one packet before resync (at least 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
byte_in  input  8  received PS/2 byte
in_valid  input  1  byte_in valid this cycle; source cannot stall, so there is no ready
pkt_data  output  24  FIFO head packet {byte1, byte2, byte3}
pkt_valid  output  1  FIFO non-empty
pkt_ready  input  1  consumer accepts head when pkt_valid is high
pkt_done  output  1  one-cycle pulse: packet assembled (stored or dropped)
pkt_count  output  $clog2(DEPTH)+1  packets currently in FIFO
overflow  output  1  sticky: a completed packet was dropped because the FIFO was full
drop_cnt  output  8  saturating count of discarded bytes (misaligned or timed-out partial)

Behaviour:
- Reset (async assert, sync release): state=SYNC. All outputs 0. FIFO empty. Idle counter 0. Byte registers 0.
- FSM states: SYNC, BYTE2, BYTE3.
  - SYNC: in_valid with byte_in[3]=1 -> latch byte1, go to BYTE2. in_valid with byte_in[3]=0 -> discard, drop_cnt+1, stay.
  - BYTE2: in_valid -> latch byte2, go to BYTE3.
  - BYTE3: in_valid -> complete packet. pkt_done=1 next cycle. Go to SYNC.
- Bytes 2/3 are taken regardless of bit 3.
- Timeout: idle counter clears on every in_valid and counts while in BYTE2/BYTE3 with no in_valid.
  - On reaching TIMEOUT-1 with no in_valid in that cycle -> go to SYNC and discard the partial packet.
  - drop_cnt += bytes held (1 in BYTE2, 2 in BYTE3), saturating at 255.
  - Counter held at 0 in SYNC.
  - in_valid on the same cycle as the timeout boundary wins: the byte is accepted normally.
- Push: on completion edge, packet written to FIFO tail unless full.
  - Full with no pop in that cycle -> packet dropped, overflow set (sticky until reset), drop_cnt unchanged.
  - Full with a pop (pkt_valid & pkt_ready) in the same cycle -> push accepted, count unchanged.
- Pop: pkt_valid & pkt_ready on an edge -> head advances.
  - pkt_data/pkt_valid are driven from registered FIFO state only; no combinational path from byte_in.
- Latency: third byte sampled at edge N -> pkt_valid=1 and pkt_data valid after edge N+1 when FIFO was empty. pkt_done is high during the same cycle.
- Ordering: FIFO strictly first-in first-out. Pointers wrap modulo DEPTH.
- pkt_count = pushes - pops. Range 0..DEPTH.
- Simultaneous push and pop on an empty FIFO is impossible (pkt_valid=0); the push proceeds.
- pkt_ready while pkt_valid=0 is ignored.
- reset_n asserted mid-packet or with a non-empty FIFO: everything cleared immediately. No packet emitted after release until a full new aligned packet arrives.

Test Plan:
1. Bytes 0x08,0x12,0x34 with in_valid, pkt_ready=1 -> one pkt_done pulse; pkt_data=0x081234 with pkt_valid for one cycle; drop_cnt=0.
2. Bytes 0x00,0x01,0x09,0xAA,0xBB -> drop_cnt=2; packet 0x09AABB emitted.
3. Byte 0x08, byte 0x11, then TIMEOUT idle cycles, then 0x18,0x22,0x33 -> drop_cnt=2; only packet 0x182233 emitted. Repeat with byte 3 arriving exactly on the boundary cycle -> packet 0x0811xx kept.
4. pkt_ready=0; send DEPTH+1 aligned packets -> pkt_count=DEPTH; overflow=1. Then assert pkt_ready -> first DEPTH packets drained in order; the last packet is absent.
5. FIFO full, pkt_ready=1, third byte on the same cycle as a pop -> overflow stays 0; pkt_count stays DEPTH; order preserved.
6. Assert reset_n low mid-packet after 0x08,0x12 with 2 packets queued -> pkt_valid=0, pkt_count=0, drop_cnt=0 immediately. Next byte 0x34 after release is discarded as misaligned (drop_cnt=1).

Source files
------------

// File: rtl/ps2_packet_sequencer_if.sv
// Byte-in / packet-out handshake bundle for the PS/2 packet sequencer.
// The sequencer itself uses the slave modport. The producer/consumer side uses master.
interface ps2_packet_sequencer_if;
  logic [7:0]  byte_in;
  logic        in_valid;
  logic [23:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;

  modport master (
    output byte_in,
    output in_valid,
    output pkt_ready,
    input  pkt_data,
    input  pkt_valid
  );

  modport slave (
    input  byte_in,
    input  in_valid,
    input  pkt_ready,
    output pkt_data,
    output pkt_valid
  );
endinterface

// File: rtl/ps2_packet_sequencer.sv
// Aligns PS/2 mouse bytes into 3-byte packets using the byte-1 sync bit.
// It resyncs on inter-byte timeout and queues complete packets in a small FIFO.
module ps2_packet_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ps2_packet_sequencer_if.slave    bus,
  output logic                     pkt_done,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StSync, StByte2, StByte3} state_e;

  state_e            state_q, state_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [7:0]        byte2_q, byte2_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [23:0]       stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic              done_q;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_q, drop_d;
  logic              overflow_q;

  logic [23:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, pop, push, ovf_set;

  always_comb begin
    state_d     = state_q;
    byte1_d     = byte1_q;
    byte2_d     = byte2_q;
    idle_d      = idle_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    drop_inc    = 2'd0;
    case (state_q)
      StSync: begin
        idle_d = '0;
        if (bus.in_valid) begin
          if (bus.byte_in[3]) begin
            byte1_d = bus.byte_in;
            state_d = StByte2;
          end else begin
            drop_inc = 2'd1;
          end
        end
      end
      StByte2, StByte3: begin
        if (bus.in_valid) begin
          // A byte landing on the timeout boundary cycle still counts.
          idle_d = '0;
          if (state_q == StByte2) begin
            byte2_d = bus.byte_in;
            state_d = StByte3;
          end else begin
            stage_d     = {byte1_q, byte2_q, bus.byte_in};
            stage_vld_d = 1'b1;
            state_d     = StSync;
          end
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          idle_d   = '0;
          state_d  = StSync;
          drop_inc = (state_q == StByte2) ? 2'd1 : 2'd2;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = StSync;
    endcase
  end

  assign drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // The assembled packet is staged for one cycle, so the push happens on the edge after byte 3.
  assign full    = (count_q == CntW'(DEPTH));
  assign pop     = (count_q != '0) & bus.pkt_ready;
  assign push    = stage_vld_q & (~full | pop);
  assign ovf_set = stage_vld_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSync;
      byte1_q     <= '0;
      byte2_q     <= '0;
      idle_q      <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      byte1_q     <= byte1_d;
      byte2_q     <= byte2_d;
      idle_q      <= idle_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      done_q      <= stage_vld_q;
      drop_q      <= drop_d;
      count_q     <= count_d;
      if (ovf_set) overflow_q <= 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= stage_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.pkt_data  = mem_q[rd_ptr_q];
  assign bus.pkt_valid = (count_q != '0);
  assign pkt_done      = done_q;
  assign pkt_count     = count_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_ps2_packet_sequencer.sv
// Randomized and directed bench for ps2_packet_sequencer.
// The reference model holds bytes, idle gaps and a packet queue.
module tb_ps2_packet_sequencer;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 16;
  localparam int unsigned CntW    = $clog2(Depth) + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pkt_done;
  logic [CntW-1:0] pkt_count;
  logic            overflow;
  logic [7:0]      drop_cnt;

  ps2_packet_sequencer_if bus ();

  ps2_packet_sequencer #(
    .DEPTH   (Depth),
    .TIMEOUT (Timeout)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [23:0] m_fifo [$];
  logic [7:0]  m_held [2];
  int          m_nheld;
  int          m_gap;
  bit          m_pend;
  logic [23:0] m_pend_pkt;
  bit          m_done;
  bit          m_ovf;
  int          m_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_nheld = 0;
    m_gap   = 0;
    m_pend  = 0;
    m_done  = 0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic model_edge(input logic [7:0] b, input bit v, input bit r);
    bit pop;
    pop    = (m_fifo.size() > 0) && r;
    m_done = m_pend;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend) begin
      if (m_fifo.size() < Depth) m_fifo.push_back(m_pend_pkt);
      else m_ovf = 1;
    end
    m_pend = 0;
    if (v) begin
      m_gap = 0;
      if (m_nheld == 0) begin
        if (b[3]) begin
          m_held[0] = b;
          m_nheld   = 1;
        end else begin
          m_drop = sat_add(m_drop, 1);
        end
      end else if (m_nheld == 1) begin
        m_held[1] = b;
        m_nheld   = 2;
      end else begin
        m_pend     = 1;
        m_pend_pkt = {m_held[0], m_held[1], b};
        m_nheld    = 0;
      end
    end else if (m_nheld > 0) begin
      m_gap++;
      if (m_gap == Timeout) begin
        m_drop  = sat_add(m_drop, m_nheld);
        m_nheld = 0;
        m_gap   = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.pkt_valid), 32'(m_fifo.size() > 0));
    check_eq({tag, ".count"}, 32'(pkt_count), 32'(m_fifo.size()));
    if (m_fifo.size() > 0) check_eq({tag, ".data"}, 32'(bus.pkt_data), 32'(m_fifo[0]));
    check_eq({tag, ".done"}, 32'(pkt_done), 32'(m_done));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input string tag, input logic [7:0] b, input bit v, input bit r);
    bus.byte_in   = b;
    bus.in_valid  = v;
    bus.pkt_ready = r;
    @(posedge clk);
    model_edge(b, v, r);
    #1;
    compare_all(tag);
  endtask

  task automatic send_pkt(input string tag, input logic [23:0] p, input bit r);
    step(tag, p[23:16], 1'b1, r);
    step(tag, p[15:8], 1'b1, r);
    step(tag, p[7:0], 1'b1, r);
  endtask

  task automatic do_reset();
    bus.byte_in   = '0;
    bus.in_valid  = 1'b0;
    bus.pkt_ready = 1'b0;
    reset_n       = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int pv;
    int pr;
    do_reset();
    check_eq("rst.valid_const", 32'(bus.pkt_valid), 32'd0);

    // 1: single packet, consumer always ready
    send_pkt("t1", 24'h081234, 1'b1);
    step("t1", 8'h00, 1'b0, 1'b1);
    check_eq("t1.done_const", 32'(pkt_done), 32'd1);
    check_eq("t1.data_const", 32'(bus.pkt_data), 32'h081234);
    step("t1", 8'h00, 1'b0, 1'b1);
    check_eq("t1.valid_gone", 32'(bus.pkt_valid), 32'd0);

    // 2: two misaligned bytes before a packet
    step("t2", 8'h00, 1'b1, 1'b0);
    step("t2", 8'h01, 1'b1, 1'b0);
    send_pkt("t2", 24'h09AABB, 1'b0);
    step("t2", 8'h00, 1'b0, 1'b0);
    check_eq("t2.drop_const", 32'(drop_cnt), 32'd2);
    check_eq("t2.data_const", 32'(bus.pkt_data), 32'h09AABB);
    step("t2", 8'h00, 1'b0, 1'b1);

    // 3: timeout discards partial; byte on the boundary cycle is kept
    do_reset();
    step("t3", 8'h08, 1'b1, 1'b1);
    step("t3", 8'h11, 1'b1, 1'b1);
    for (int i = 0; i < Timeout; i++) step("t3.idle", 8'h00, 1'b0, 1'b1);
    send_pkt("t3", 24'h182233, 1'b0);
    step("t3", 8'h00, 1'b0, 1'b0);
    check_eq("t3.drop_const", 32'(drop_cnt), 32'd2);
    check_eq("t3.data_const", 32'(bus.pkt_data), 32'h182233);
    check_eq("t3.count_const", 32'(pkt_count), 32'd1);
    step("t3", 8'h00, 1'b0, 1'b1);
    step("t3b", 8'h08, 1'b1, 1'b0);
    step("t3b", 8'h11, 1'b1, 1'b0);
    for (int i = 0; i < Timeout - 1; i++) step("t3b.idle", 8'h00, 1'b0, 1'b0);
    step("t3b", 8'h55, 1'b1, 1'b0);
    step("t3b", 8'h00, 1'b0, 1'b0);
    check_eq("t3b.data_const", 32'(bus.pkt_data), 32'h081155);
    check_eq("t3b.drop_const", 32'(drop_cnt), 32'd2);
    step("t3b", 8'h00, 1'b0, 1'b1);

    // 4: overflow with Depth+1 packets, then drain in order
    do_reset();
    for (int i = 0; i <= Depth; i++) begin
      send_pkt("t4.fill", {8'h08, 8'(i), 8'(8'h40 + i)}, 1'b0);
      step("t4.fill", 8'h00, 1'b0, 1'b0);
    end
    check_eq("t4.count_const", 32'(pkt_count), 32'(Depth));
    check_eq("t4.ovf_const", 32'(overflow), 32'd1);
    for (int i = 0; i < Depth; i++) begin
      check_eq("t4.order", 32'(bus.pkt_data), 32'({8'h08, 8'(i), 8'(8'h40 + i)}));
      step("t4.drain", 8'h00, 1'b0, 1'b1);
    end
    check_eq("t4.empty", 32'(bus.pkt_valid), 32'd0);

    // 5: push into full FIFO on the same edge as a pop
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      send_pkt("t5.fill", {8'h18, 8'(i), 8'(8'h70 + i)}, 1'b0);
      step("t5.fill", 8'h00, 1'b0, 1'b0);
    end
    send_pkt("t5", 24'h2BCDEF, 1'b0);
    step("t5.pop", 8'h00, 1'b0, 1'b1);
    check_eq("t5.ovf_const", 32'(overflow), 32'd0);
    check_eq("t5.count_const", 32'(pkt_count), 32'(Depth));
    for (int i = 0; i < Depth; i++) step("t5.drain", 8'h00, 1'b0, 1'b1);
    step("t5.drain", 8'h00, 1'b0, 1'b0);

    // 6: reset mid-packet with packets queued
    do_reset();
    send_pkt("t6", 24'h0A0B0C, 1'b0);
    send_pkt("t6", 24'h0D0E0F, 1'b0);
    step("t6", 8'h08, 1'b1, 1'b0);
    step("t6", 8'h12, 1'b1, 1'b0);
    check_eq("t6.count_pre", 32'(pkt_count), 32'd2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6.valid_rst", 32'(bus.pkt_valid), 32'd0);
    check_eq("t6.count_rst", 32'(pkt_count), 32'd0);
    check_eq("t6.drop_rst", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step("t6", 8'h34, 1'b1, 1'b0);
    check_eq("t6.drop_const", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 3; i++) step("t6.idle", 8'h00, 1'b0, 1'b1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) step("sat", 8'h00, 1'b1, 1'b1);
    check_eq("sat.const", 32'(drop_cnt), 32'd255);

    // randomized traffic with varying density and back-pressure
    do_reset();
    for (int blk = 0; blk < 60; blk++) begin
      case ($urandom_range(0, 2))
        0:       pv = 90;
        1:       pv = 50;
        default: pv = 5;
      endcase
      case ($urandom_range(0, 2))
        0:       pr = 80;
        1:       pr = 30;
        default: pr = 0;
      endcase
      for (int c = 0; c < 64; c++)
        step("rnd", 8'($urandom), ($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
